// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state encoding and access-size helper
// for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Access size implied by funct3; reserved encodings behave as a word.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/halfword out of a read word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension; anything not B/H/BU/HU is a word.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: performs the data-memory access for RV32I loads/stores
// and stalls the pipeline while it is outstanding.
// Optional macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses with
// lsu_err instead of forcing natural alignment).
//
// Request channel: a request is transferred on a rising edge where both
// mem_req_valid and mem_req_ready are high; once valid rises it stays high
// with all mem_* fields stable until that edge. The response channel has no
// back-pressure: mem_rsp_valid is sampled only while waiting for a response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_load,
    input  logic        is_s_instr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        lsu_busy,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_err
);

    localparam logic [CNT_W:0] TMO = (CNT_W+1)'(RSP_TIMEOUT);

    lsu_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             timeout_hit;

    logic             cap_load;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [3:0]       req_wstrb;
    logic [2:0]       cap_f3;
    logic [1:0]       cap_lo;
    logic [4:0]       cap_rd;

    logic             start;
    logic             trap;
    lsu_size_e        sz;
    logic [1:0]       lo_aligned;
    logic [31:0]      wdata_lane;
    logic [3:0]       wstrb_lane;
    logic [31:0]      load_ext;

    // Gated by rst_n so that every output reads 0 while reset is held.
    assign start = rst_n && (is_load || is_s_instr);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = start &&
                  (((sz == SZ_H) && addr[0]) || ((sz == SZ_W) && (addr[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    assign cnt_inc     = {1'b0, cnt} + 1'b1;
    assign timeout_hit = (RSP_TIMEOUT != 0) && (cnt_inc == TMO);

    assign mem_we    = req_we;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;
    assign mem_wstrb = req_wstrb;

    // Natural alignment of the low address bits plus store lane replication.
    always_comb begin
        sz         = f3_size(funct3);
        lo_aligned = 2'b00;
        wdata_lane = store_data;
        wstrb_lane = 4'b1111;
        case (sz)
            SZ_B: begin
                lo_aligned = addr[1:0];
                wdata_lane = {4{store_data[7:0]}};
                wstrb_lane = 4'b0001 << addr[1:0];
            end
            SZ_H: begin
                lo_aligned = {addr[1], 1'b0};
                wdata_lane = {2{store_data[15:0]}};
                wstrb_lane = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                lo_aligned = 2'b00;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (cap_lo),
        .funct3  (cap_f3),
        .data    (load_ext)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake/stall outputs.
    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        lsu_busy      = 1'b0;
        wb_valid      = 1'b0;
        case (state)
            ST_IDLE: begin
                lsu_busy = start;
                if (start && !trap) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                lsu_busy      = 1'b1;
                if (mem_req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                lsu_busy = 1'b1;
                if (mem_rsp_valid)    state_nxt = ST_DONE;
                else if (timeout_hit) state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                wb_valid  = cap_load;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, response counter, writeback registers and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cap_load  <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
            req_wstrb <= 4'd0;
            cap_f3    <= 3'd0;
            cap_lo    <= 2'd0;
            cap_rd    <= 5'd0;
            wb_data   <= 32'd0;
            wb_rd     <= 5'd0;
            lsu_err   <= 1'b0;
        end else begin
            lsu_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (trap) begin
                            lsu_err <= 1'b1;
                        end else begin
                            cap_load  <= is_load;
                            req_we    <= !is_load;
                            req_addr  <= {addr[31:2], 2'b00};
                            req_wdata <= wdata_lane;
                            req_wstrb <= is_load ? 4'b0000 : wstrb_lane;
                            cap_f3    <= funct3;
                            cap_lo    <= lo_aligned;
                            cap_rd    <= rd_in;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) cnt <= '0;
                end
                ST_WAIT: begin
                    cnt <= cnt_inc[CNT_W-1:0];
                    if (mem_rsp_valid) begin
                        if (cap_load) begin
                            wb_data <= load_ext;
                            wb_rd   <= cap_rd;
                        end
                    end else if (timeout_hit) begin
                        lsu_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses checked cycle by cycle
// against a byte-arithmetic reference model of the load/store unit.
module tb_load_store_unit;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        is_load = 1'b0;
    logic        is_s_instr = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        lsu_busy;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_err;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    load_store_unit #(.RSP_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .is_load       (is_load),
        .is_s_instr    (is_s_instr),
        .funct3        (funct3),
        .addr          (addr),
        .store_data    (store_data),
        .rd_in         (rd_in),
        .lsu_busy      (lsu_busy),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .lsu_err       (lsu_err)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [1:0] aligned_lo(input logic [2:0] f3, input logic [1:0] lo);
        int l;
        l = int'(lo);
        return 2'(l - (l % nbytes(f3)));
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [1:0] lo);
        int m;
        m = ((1 << nbytes(f3)) - 1) << int'(aligned_lo(f3, lo));
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (nbytes(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
        int nb;
        logic [31:0] v, mask;
        nb = nbytes(f3);
        if (nb == 4) return rdata;
        v    = rdata >> (8 * int'(aligned_lo(f3, lo)));
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = v & mask;
        if (f3[2] == 1'b0 && ((v >> (8 * nb - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, lsu_busy, 0);
        check({tag, "_valid"}, mem_req_valid, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_wstrb"}, mem_wstrb, 0);
        check({tag, "_wbv"}, wb_valid, 0);
        check({tag, "_wbrd"}, wb_rd, 0);
        check({tag, "_wbdata"}, wb_data, 0);
        check({tag, "_err"}, lsu_err, 0);
    endtask

    // One full access from the IDLE start cycle; called at a drive point.
    task automatic run_access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [4:0] rd,
                              input int rdy_dly, input int rsp_dly,
                              input logic [31:0] rdata, input bit no_rsp);
        bit trap;
        logic [31:0] e;
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (int'(a[1:0]) % nbytes(f3)) != 0;
`endif
        is_load    = ld;
        is_s_instr = ld ? 1'($urandom_range(0, 1)) : 1'b1;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        rd_in      = rd;
        @(negedge clk);
        check("start_busy", lsu_busy, 1);
        check("start_valid", mem_req_valid, 0);
        next_cycle();
        is_load    = 1'b0;
        is_s_instr = 1'b0;
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
        rd_in      = 5'($urandom);

        if (trap) begin
            @(negedge clk);
            check("trap_err", lsu_err, 1);
            check("trap_valid", mem_req_valid, 0);
            check("trap_busy", lsu_busy, 0);
            next_cycle();
            @(negedge clk);
            check("trap_err_clr", lsu_err, 0);
            check("trap_valid2", mem_req_valid, 0);
            next_cycle();
            return;
        end

        for (int i = 0; i <= rdy_dly; i++) begin
            mem_req_ready = (i == rdy_dly);
            @(negedge clk);
            check("req_valid", mem_req_valid, 1);
            check("req_busy", lsu_busy, 1);
            check("req_we", mem_we, !ld);
            check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            check("req_wstrb", mem_wstrb, ld ? 4'b0000 : model_wstrb(f3, a[1:0]));
            if (!ld) check("req_wdata", mem_wdata, model_wdata(f3, sd));
            next_cycle();
        end
        mem_req_ready = 1'($urandom_range(0, 1));

        if (no_rsp) begin
            for (int k = 0; k < TMO; k++) begin
                mem_rdata = $urandom;
                @(negedge clk);
                check("wait_busy", lsu_busy, 1);
                check("wait_valid", mem_req_valid, 0);
                check("wait_err", lsu_err, 0);
                next_cycle();
            end
            @(negedge clk);
            check("tmo_err", lsu_err, 1);
            check("tmo_busy", lsu_busy, 0);
            check("tmo_wbv", wb_valid, 0);
            next_cycle();
            @(negedge clk);
            check("tmo_err_clr", lsu_err, 0);
            check("tmo_wbv2", wb_valid, 0);
            next_cycle();
            return;
        end

        for (int k = 0; k < rsp_dly; k++) begin
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
            @(negedge clk);
            check("wait_busy", lsu_busy, 1);
            check("wait_valid", mem_req_valid, 0);
            check("wait_err", lsu_err, 0);
            check("wait_wbv", wb_valid, 0);
            next_cycle();
        end
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        if (ld) exp_q.push_back(model_load(f3, a[1:0], rdata));
        @(negedge clk);
        check("rsp_busy", lsu_busy, 1);
        next_cycle();
        mem_rsp_valid = 1'b0;
        mem_rdata     = $urandom;

        @(negedge clk);
        check("done_wbv", wb_valid, ld);
        check("done_busy", lsu_busy, 0);
        check("done_err", lsu_err, 0);
        check("done_valid", mem_req_valid, 0);
        if (ld) begin
            e = exp_q.pop_front();
            check("wb_rd", wb_rd, rd);
            check("wb_data", wb_data, e);
        end
        next_cycle();
        @(negedge clk);
        check("idle_wbv", wb_valid, 0);
        check("idle_busy", lsu_busy, 0);
        next_cycle();
    endtask

    // Start a load and pull reset low mid-cycle while in REQ or WAIT.
    task automatic reset_mid(input bit in_wait);
        is_load    = 1'b1;
        funct3     = 3'b010;
        addr       = 32'h0000_0404;
        rd_in      = 5'd9;
        mem_req_ready = 1'b0;
        next_cycle();
        is_load = 1'b0;
        if (in_wait) begin
            mem_req_ready = 1'b1;
            next_cycle();
            mem_req_ready = 1'b0;
            next_cycle();
            check("pre_rst_busy", lsu_busy, 1);
        end else begin
            check("pre_rst_valid", mem_req_valid, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(in_wait ? "rst_wait" : "rst_req");
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        is_load = 1'b1;
        #3;
        check_idle_outputs("reset");
        is_load = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Directed cases.
        run_access(0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'd0, 0);
        run_access(0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd0, 0, 0, 32'd0, 0);
        run_access(0, 3'b001, 32'h0000_0302, 32'h1234_BEEF, 5'd0, 0, 2, 32'd0, 0);
        run_access(1, 3'b000, 32'h0000_0202, 32'd0, 5'd5, 0, 0, 32'h1280_FF00, 0);
        run_access(1, 3'b100, 32'h0000_0202, 32'd0, 5'd6, 0, 0, 32'h1280_FF00, 0);
        run_access(1, 3'b101, 32'h0000_0202, 32'd0, 5'd7, 0, 0, 32'h1280_FF00, 0);
        run_access(1, 3'b001, 32'h0000_0200, 32'd0, 5'd8, 0, 1, 32'h1280_FF00, 0);
        run_access(0, 3'b010, 32'h0000_0500, 32'hCAFE_F00D, 5'd0, 4, 0, 32'd0, 0);
        run_access(1, 3'b010, 32'h0000_0600, 32'd0, 5'd3, 4, 1, 32'h89AB_CDEF, 0);
        run_access(1, 3'b010, 32'h0000_0700, 32'd0, 5'd4, 0, 0, 32'd0, 1);
        run_access(1, 3'b100, 32'h0000_0701, 32'd0, 5'd11, 0, TMO - 1, 32'h0000_9C00, 0);
        reset_mid(1);
        reset_mid(0);
        run_access(1, 3'b010, 32'h0000_0102, 32'd0, 5'd12, 0, 0, 32'h1122_3344, 0);
        run_access(0, 3'b001, 32'h0000_0105, 32'h0000_7788, 5'd0, 0, 0, 32'd0, 0);

        // Randomized accesses.
        for (int n = 0; n < 80; n++) begin
            bit ld;
            ld = 1'($urandom_range(0, 1));
            run_access(ld, f3_tab[$urandom_range(0, 7)], $urandom, $urandom,
                       5'($urandom), $urandom_range(0, 3), $urandom_range(0, TMO - 1),
                       $urandom, ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
